branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and misprediction detector for the RV32I 5-stage pipeline. In IF it looks up the fetch PC in a direct-mapped branch target table (2-bit saturating counter plus target per entry) and supplies a predicted next PC. In EX it compares the prediction carried down the pipe with the resolved branch decision and target. On a mismatch it raises a redirect to the PC mux and hazard unit, which performs the IF/ID flush, and it trains the table.

## Interface
- INDEX_BITS, 4, table has 2^INDEX_BITS entries; index = pc[INDEX_BITS+1:2]
- XLEN, 32, address width; tag = pc[XLEN-1:INDEX_BITS+2]

- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  reset; **one clock, reset asynchronous and active-low**
- if_pc  in  XLEN  current fetch PC
- pred_taken  out  1  IF prediction: branch predicted taken
- pred_target  out  XLEN  predicted next PC (entry target if predicted taken, else if_pc+4)
- ex_valid  in  1  EX holds a real instruction (0 for bubble/flushed/stalled-repeat)
- ex_pc  in  XLEN  PC of EX instruction
- ex_br_instr  in  2  11 = B-type, 01 = J-type, 00 = other (same encoding as branch decision logic)
- ex_br_taken  in  1  resolved decision from branch decision logic
- ex_target  in  XLEN  resolved target address
- ex_pred_taken  in  1  pred_taken carried from IF with this instruction
- ex_pred_target  in  XLEN  pred_target carried from IF
- mispredict  out  1  redirect required this cycle
- redirect_pc  out  XLEN  correct next PC when mispredict=1
- branch_cnt  out  32  resolved branch/jump count
- mispred_cnt  out  32  mispredict count

## Operation
- Entry fields: valid, tag, target[XLEN-1:0], ctr[1:0] (00 SNT, 01 WNT, 10 WT, 11 ST).
- Lookup (combinational from registered table): hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = pred_taken ? target : if_pc+4.
- Resolve (combinational, only when ex_valid=1):
  - Branch/jump (ex_br_instr[0]=1): mispredict = (ex_br_taken != ex_pred_taken) || (ex_br_taken && ex_target != ex_pred_target).
  - Non-branch with ex_pred_taken=1: mispredict=1.
  - redirect_pc = ex_br_taken ? ex_target : ex_pc+4.
  - ex_valid=0: mispredict=0, no update; redirect_pc is don't-care but is driven ex_pc+4.
- Training at the rising edge, when ex_valid=1, indexed by ex_pc:
  - Hit, B-type: taken → ctr+1 saturating at 11; not taken → ctr-1 saturating at 00. Target is rewritten with ex_target when taken.
  - Hit, J-type: ctr←11, target←ex_target.
  - Miss, taken: allocate and overwrite with valid=1, tag, target=ex_target, ctr=10 for B-type or 11 for J-type.
  - Miss, not taken: no write.
  - Non-branch that hits: valid←0.
- Counters increment by 1 each edge:
  - branch_cnt: ex_valid && ex_br_instr[0].
  - mispred_cnt: mispredict.
  - Both saturate at 0xFFFFFFFF; no wrap.

## Timing
- Prediction: zero latency, same cycle as if_pc.
- mispredict/redirect_pc: combinational in the EX cycle; the PC loads redirect_pc at the next edge; table and counters update at that same edge.
- Read-during-write: when IF reads the index that EX trains in the same cycle, IF sees the old entry. There is no bypass.
- EX stall: upstream must deassert ex_valid on repeated cycles, so each instruction trains exactly once.
- Reset (asynchronous, at any time, including mid-update): all valid←0, ctr←01, target←0, counters←0. Any in-flight write is discarded. Outputs during and after reset: pred_taken=0, pred_target=if_pc+4, mispredict=0 (ex_valid is expected low).

## Test plan
- Reset, then BEQ at 0x100 with ex_br_taken=1, target 0x80, ex_pred_taken=0 → mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 → pred_taken=1, pred_target=0x80, entry ctr=10.
- Same branch taken 3 more times, then not taken with ex_pred_taken=1 → ctr 11 saturates. Not-taken resolve: mispredict=1, redirect_pc=0x104, ctr=10, prediction still taken.
- JAL at 0x200, target 0x400, cold → mispredict=1. Second pass with pred carried (1, 0x400) → mispredict=0, ctr=11.
- Taken B-type at 0x100 resolves with target 0x90 while pred was (1, 0x80) → mispredict=1, redirect_pc=0x90, entry target becomes 0x90.
- Aliasing: 0x100 allocated, then 0x140 (same index with INDEX_BITS=4) taken → 0x140 replaces it, and lookup of 0x100 misses. Non-branch at 0x140 with ex_pred_taken=1 → mispredict=1, redirect_pc=0x144, entry invalidated.
- ex_valid=0 with mismatching inputs → no mispredict, no update, counters unchanged. Assert rst_n low between edges mid-training → table and counters cleared immediately, and pred_taken=0 for all PCs.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target table with 2-bit counters: IF-stage prediction,
// EX-stage misprediction detection/redirect, table training and event counters.

module bp_entry #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic             valid_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [XLEN-1:0]  target_i,
    input  logic [1:0]       ctr_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [XLEN-1:0]  target_o,
    output logic [1:0]       ctr_o
);
    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  target_q;
    logic [1:0]       ctr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= 2'b01;
        end else if (we_i) begin
            valid_q  <= valid_i;
            tag_q    <= tag_i;
            target_q <= target_i;
            ctr_q    <= ctr_i;
        end
    end

    assign valid_o  = valid_q;
    assign tag_o    = tag_q;
    assign target_o = target_q;
    assign ctr_o    = ctr_q;
endmodule

module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [1:0]      ex_br_instr,
    input  logic            ex_br_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);
    localparam int N     = 1 << INDEX_BITS;
    localparam int TAG_W = XLEN - INDEX_BITS - 2;

    logic [N-1:0]            ent_valid;
    logic [N-1:0][TAG_W-1:0] ent_tag;
    logic [N-1:0][XLEN-1:0]  ent_target;
    logic [N-1:0][1:0]       ent_ctr;
    logic [N-1:0]            ent_we;

    logic                  wr_en;
    logic                  wr_valid_d;
    logic [TAG_W-1:0]      wr_tag_d;
    logic [XLEN-1:0]       wr_target_d;
    logic [1:0]            wr_ctr_d;

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]      if_tag, ex_tag;
    logic                  if_hit, ex_hit;
    logic                  is_br, is_b;
    logic [1:0]            ex_ctr;

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    for (genvar g = 0; g < N; g++) begin : g_ent
        bp_entry #(.XLEN(XLEN), .TAG_W(TAG_W)) u_ent (
            .clk      (clk),
            .rst_n    (rst_n),
            .we_i     (ent_we[g]),
            .valid_i  (wr_valid_d),
            .tag_i    (wr_tag_d),
            .target_i (wr_target_d),
            .ctr_i    (wr_ctr_d),
            .valid_o  (ent_valid[g]),
            .tag_o    (ent_tag[g]),
            .target_o (ent_target[g]),
            .ctr_o    (ent_ctr[g])
        );
    end

    // IF lookup reads registered entries only: a same-cycle EX write is not bypassed.
    assign if_idx      = if_pc[INDEX_BITS+1:2];
    assign if_tag      = if_pc[XLEN-1:INDEX_BITS+2];
    assign if_hit      = ent_valid[if_idx] && (ent_tag[if_idx] == if_tag);
    assign pred_taken  = if_hit && ent_ctr[if_idx][1];
    assign pred_target = pred_taken ? ent_target[if_idx] : if_pc + XLEN'(4);

    assign ex_idx = ex_pc[INDEX_BITS+1:2];
    assign ex_tag = ex_pc[XLEN-1:INDEX_BITS+2];
    assign ex_hit = ent_valid[ex_idx] && (ent_tag[ex_idx] == ex_tag);
    assign ex_ctr = ent_ctr[ex_idx];
    assign is_br  = ex_br_instr[0];
    assign is_b   = ex_br_instr[1] && ex_br_instr[0];

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = ex_pc + XLEN'(4);
        if (ex_valid) begin
            if (ex_br_taken) redirect_pc = ex_target;
            if (is_br)
                mispredict = (ex_br_taken != ex_pred_taken) ||
                             (ex_br_taken && (ex_target != ex_pred_target));
            else
                mispredict = ex_pred_taken;
        end
    end

    always_comb begin
        wr_en       = 1'b0;
        wr_valid_d  = ent_valid[ex_idx];
        wr_tag_d    = ex_tag;
        wr_target_d = ent_target[ex_idx];
        wr_ctr_d    = ex_ctr;
        if (ex_valid) begin
            if (is_br && ex_hit) begin
                wr_en      = 1'b1;
                wr_valid_d = 1'b1;
                if (is_b) begin
                    if (ex_br_taken) begin
                        wr_ctr_d    = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'd1;
                        wr_target_d = ex_target;
                    end else begin
                        wr_ctr_d    = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'd1;
                    end
                end else begin
                    wr_ctr_d    = 2'b11;
                    wr_target_d = ex_target;
                end
            end else if (is_br && ex_br_taken) begin
                // Miss: allocate, evicting whatever alias owned the slot.
                wr_en       = 1'b1;
                wr_valid_d  = 1'b1;
                wr_target_d = ex_target;
                wr_ctr_d    = is_b ? 2'b10 : 2'b11;
            end else if (!is_br && ex_hit) begin
                wr_en      = 1'b1;
                wr_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        ent_we = '0;
        if (wr_en) ent_we[ex_idx] = 1'b1;
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (ex_valid && is_br && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 32'd1;
        if (mispredict && (mispred_cnt_q != '1))       mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic against an array-based behavioural model of the predictor table.

module tb_branch_predictor;
    localparam int IB = 4;
    localparam int N  = 1 << IB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc, ex_pc, ex_target, ex_pred_target;
    logic [31:0] pred_target, redirect_pc, branch_cnt, mispred_cnt;
    logic [1:0]  ex_br_instr;
    logic        ex_valid, ex_br_taken, ex_pred_taken, pred_taken, mispredict;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(IB), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_br_instr    (ex_br_instr),
        .ex_br_taken    (ex_br_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: one record per table slot, counter as a plain 0..3 int.
    bit          m_v[N];
    int unsigned m_tag[N];
    logic [31:0] m_tgt[N];
    int          m_ctr[N];
    longint      m_bc, m_mc;

    logic        e_pt, e_mp;
    logic [31:0] e_ptg, e_rpc;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 32'h0; m_ctr[i] = 1;
        end
        m_bc = 0; m_mc = 0;
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[m_idx(pc)] && (m_tag[m_idx(pc)] == pc / (4 * N));
    endfunction

    function automatic void m_pred(input logic [31:0] pc, output logic pt, output logic [31:0] ptg);
        pt  = m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
        ptg = pt ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic void m_eval();
        m_pred(if_pc, e_pt, e_ptg);
        e_mp  = 1'b0;
        e_rpc = ex_pc + 32'd4;
        if (ex_valid) begin
            if (ex_br_taken) e_rpc = ex_target;
            if (ex_br_instr == 2'b11 || ex_br_instr == 2'b01)
                e_mp = (ex_br_taken != ex_pred_taken) || (ex_br_taken && ex_target != ex_pred_target);
            else
                e_mp = ex_pred_taken;
        end
    endfunction

    function automatic void m_train();
        int  i;
        bit  br, btype, hit;
        i     = m_idx(ex_pc);
        btype = (ex_br_instr == 2'b11);
        br    = btype || (ex_br_instr == 2'b01);
        hit   = m_hit(ex_pc);
        if (!ex_valid) return;
        if (br && hit) begin
            if (btype) begin
                if (ex_br_taken) begin
                    m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = ex_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                end
            end else begin
                m_ctr[i] = 3;
                m_tgt[i] = ex_target;
            end
        end else if (br && ex_br_taken) begin
            m_v[i] = 1; m_tag[i] = ex_pc / (4 * N); m_tgt[i] = ex_target;
            m_ctr[i] = btype ? 2 : 3;
        end else if (!br && hit) begin
            m_v[i] = 0;
        end
        if (br && m_bc < 64'hFFFF_FFFF) m_bc++;
        if (e_mp && m_mc < 64'hFFFF_FFFF) m_mc++;
    endfunction

    task automatic drive(input logic [31:0] ipc, input logic v, input logic [31:0] pc,
                         input logic [1:0] k, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptg);
        if_pc = ipc; ex_valid = v; ex_pc = pc; ex_br_instr = k; ex_br_taken = tk;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptg;
        #1;
        m_eval();
    endtask

    task automatic tick();
        m_train();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h100 + 32'(i * 64), 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
            vectors++;
            if (pred_taken !== 1'b0 || pred_target !== if_pc + 32'd4 || mispredict !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_out pc=%h got pt=%b tgt=%h mp=%b exp pt=0 tgt=%h mp=0",
                         if_pc, pred_taken, pred_target, mispredict, if_pc + 32'd4);
            end
        end
        vectors++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got %0d/%0d exp 0/0", branch_cnt, mispred_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] ipc; logic v; logic [31:0] pc; logic [1:0] k; logic tk;
        logic [31:0] tgt; logic ptk; logic [31:0] ptg; logic x_mp; logic x_pt;
    } step_t;

    task automatic test_directed();
        step_t s[$];
        s.push_back('{32'h100, 1, 32'h100, 2'b11, 1, 32'h80,  0, 32'h104, 1, 0});
        s.push_back('{32'h100, 0, 32'h100, 2'b11, 1, 32'h80,  0, 32'h104, 0, 1});
        for (int r = 0; r < 3; r++)
            s.push_back('{32'h100, 1, 32'h100, 2'b11, 1, 32'h80, 1, 32'h80, 0, 1});
        s.push_back('{32'h100, 1, 32'h100, 2'b11, 0, 32'h80,  1, 32'h80,  1, 1});
        s.push_back('{32'h100, 0, 32'h0,   2'b00, 0, 32'h0,   0, 32'h0,   0, 1});
        s.push_back('{32'h200, 1, 32'h200, 2'b01, 1, 32'h400, 0, 32'h204, 1, 0});
        s.push_back('{32'h200, 1, 32'h200, 2'b01, 1, 32'h400, 1, 32'h400, 0, 1});
        s.push_back('{32'h100, 0, 32'h0,   2'b00, 0, 32'h0,   0, 32'h0,   0, 0});
        s.push_back('{32'h100, 1, 32'h100, 2'b11, 1, 32'h90,  1, 32'h80,  1, 0});
        s.push_back('{32'h100, 0, 32'h0,   2'b00, 0, 32'h0,   0, 32'h0,   0, 1});
        s.push_back('{32'h140, 1, 32'h140, 2'b11, 1, 32'h300, 0, 32'h144, 1, 0});
        s.push_back('{32'h100, 0, 32'h0,   2'b00, 0, 32'h0,   0, 32'h0,   0, 0});
        s.push_back('{32'h140, 1, 32'h140, 2'b00, 0, 32'h0,   1, 32'h300, 1, 1});
        s.push_back('{32'h140, 0, 32'h0,   2'b00, 0, 32'h0,   0, 32'h0,   0, 0});
        foreach (s[j]) begin
            drive(s[j].ipc, s[j].v, s[j].pc, s[j].k, s[j].tk, s[j].tgt, s[j].ptk, s[j].ptg);
            vectors++;
            if (mispredict !== s[j].x_mp || pred_taken !== s[j].x_pt) begin
                miscompares++;
                $display("FAIL directed_%0d got mp=%b pt=%b exp mp=%b pt=%b",
                         j, mispredict, pred_taken, s[j].x_mp, s[j].x_pt);
            end
            vectors++;
            if (pred_target !== e_ptg || redirect_pc !== e_rpc || mispredict !== e_mp) begin
                miscompares++;
                $display("FAIL directed_model_%0d got tgt=%h rpc=%h mp=%b exp tgt=%h rpc=%h mp=%b",
                         j, pred_target, redirect_pc, mispredict, e_ptg, e_rpc, e_mp);
            end
            tick();
            vectors++;
            if (branch_cnt !== m_bc[31:0] || mispred_cnt !== m_mc[31:0]) begin
                miscompares++;
                $display("FAIL directed_cnt_%0d got %0d/%0d exp %0d/%0d",
                         j, branch_cnt, mispred_cnt, m_bc, m_mc);
            end
        end
    endtask

    task automatic test_ex_invalid();
        for (int j = 0; j < 20; j++) begin
            drive(32'h100 + 32'(($urandom % 32) * 4), 1'b0, 32'h100 + 32'(($urandom % 32) * 4),
                  2'($urandom), $urandom % 2 == 0, $urandom, 1'b1, $urandom);
            vectors++;
            if (mispredict !== 1'b0 || pred_taken !== e_pt || pred_target !== e_ptg
                || redirect_pc !== ex_pc + 32'd4) begin
                miscompares++;
                $display("FAIL ex_invalid got mp=%b pt=%b tgt=%h rpc=%h exp mp=0 pt=%b tgt=%h rpc=%h",
                         mispredict, pred_taken, pred_target, redirect_pc, e_pt, e_ptg, ex_pc + 32'd4);
            end
            tick();
            vectors++;
            if (branch_cnt !== m_bc[31:0] || mispred_cnt !== m_mc[31:0]) begin
                miscompares++;
                $display("FAIL ex_invalid_cnt got %0d/%0d exp %0d/%0d", branch_cnt, mispred_cnt, m_bc, m_mc);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] pc, ipc, tgt, ptg;
        logic [1:0]  k;
        logic        tk, ptk, v;
        for (int j = 0; j < 600; j++) begin
            pc  = 32'h1000 + 32'($urandom_range(0, 95) * 4);
            ipc = ($urandom % 2 == 0) ? pc : 32'h1000 + 32'($urandom_range(0, 95) * 4);
            case ($urandom % 4)
                0: k = 2'b00;
                1: k = 2'b01;
                2: k = 2'b11;
                default: k = 2'b10;
            endcase
            tk  = (k == 2'b01) ? 1'b1 : ($urandom % 2 == 0);
            tgt = ($urandom % 4 == 0) ? $urandom : 32'h2000 + 32'($urandom_range(0, 3) * 4);
            m_pred(pc, ptk, ptg);
            if ($urandom % 4 == 0) begin
                ptk = $urandom % 2 == 0;
                ptg = 32'h2000 + 32'($urandom_range(0, 3) * 4);
            end
            v = ($urandom % 8) != 0;
            drive(ipc, v, pc, k, tk, tgt, ptk, ptg);
            vectors++;
            if (pred_taken !== e_pt || pred_target !== e_ptg || mispredict !== e_mp
                || redirect_pc !== e_rpc) begin
                miscompares++;
                $display("FAIL random_%0d got pt=%b tgt=%h mp=%b rpc=%h exp pt=%b tgt=%h mp=%b rpc=%h",
                         j, pred_taken, pred_target, mispredict, redirect_pc, e_pt, e_ptg, e_mp, e_rpc);
            end
            tick();
            vectors++;
            if (branch_cnt !== m_bc[31:0] || mispred_cnt !== m_mc[31:0]) begin
                miscompares++;
                $display("FAIL random_cnt_%0d got %0d/%0d exp %0d/%0d",
                         j, branch_cnt, mispred_cnt, m_bc, m_mc);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Make sure 0x180 is trained and predicted taken before the reset hits.
        drive(32'h180, 1'b1, 32'h180, 2'b01, 1'b1, 32'h500, 1'b0, 32'h184);
        tick();
        drive(32'h180, 1'b1, 32'h1c0, 2'b11, 1'b1, 32'h600, 1'b0, 32'h1c4);
        vectors++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h500) begin
            miscompares++;
            $display("FAIL reset_mid_pre got pt=%b tgt=%h exp pt=1 tgt=00000500", pred_taken, pred_target);
        end
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        vectors++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_cnt got %0d/%0d exp 0/0", branch_cnt, mispred_cnt);
        end
        for (int i = 0; i < 2 * N; i++) begin
            if_pc = 32'h1000 + 32'(i * 4);
            #1;
            vectors++;
            if (pred_taken !== 1'b0 || pred_target !== if_pc + 32'd4) begin
                miscompares++;
                $display("FAIL reset_mid_pred pc=%h got pt=%b tgt=%h exp pt=0", if_pc, pred_taken, pred_target);
            end
        end
        @(negedge clk);
        ex_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        drive(32'h1c0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        vectors++;
        if (pred_taken !== 1'b0 || mispredict !== 1'b0 || branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_post got pt=%b mp=%b cnt=%0d/%0d exp 0 0 0/0",
                     pred_taken, mispredict, branch_cnt, mispred_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m_reset();
        drive(32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        test_reset();
        test_directed();
        test_ex_invalid();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
